// File: rtl/motor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : motor_sequencer
// Brief    : H-bridge direction/duty sequencer with soft ramp, dead-time coast
//            and filtered overcurrent handling. Define OC_AUTO_RETRY_EN for
//            timed automatic re-arm after a fault instead of immediate lockout.
// Revision : 1.0
// ============================================================================
module motor_sequencer #(
    parameter int DEADTIME_CYC = 1000,
    parameter int RAMP_DIV     = 256,
    parameter int RAMP_STEP    = 16,
    parameter int OC_FILTER    = 2,
    parameter int RETRY_CYC    = 50000,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sw,
    input  logic [1:0]  OC,
    input  logic        pulse,
    output logic [3:0]  IN,
    output logic [1:0]  EN,
    output logic [11:0] duty,
    output logic        fault
);

    localparam int c_CNT_MAX  = (DEADTIME_CYC > RETRY_CYC) ? DEADTIME_CYC : RETRY_CYC;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam int c_PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int c_OCF_W    = $clog2(OC_FILTER + 1);
    localparam int c_FCNT_W   = $clog2(MAX_RETRY + 2);

    localparam logic [c_CNT_W-1:0]  c_DEAD_LAST  = c_CNT_W'(DEADTIME_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_RETRY_LAST = c_CNT_W'(RETRY_CYC - 1);
    localparam logic [c_PRE_W-1:0]  c_PRE_LAST   = c_PRE_W'(RAMP_DIV - 1);
    localparam logic [c_OCF_W-1:0]  c_OCF_MAX    = c_OCF_W'(OC_FILTER);
    localparam logic [c_OCF_W-1:0]  c_OCF_ARM    = c_OCF_W'(OC_FILTER - 1);
    localparam logic [c_FCNT_W-1:0] c_FCNT_MAX   = c_FCNT_W'(MAX_RETRY + 1);
    localparam logic [12:0]         c_STEP       = 13'(RAMP_STEP);

    typedef enum logic [2:0] {
        c_IDLE       = 3'd0,
        c_RAMP       = 3'd1,
        c_RUN        = 3'd2,
        c_DEAD       = 3'd3,
        c_FAULT      = 3'd4,
        c_RETRY_WAIT = 3'd5,
        c_LOCKOUT    = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_in;
    logic [11:0]          r_duty;
    logic [c_PRE_W-1:0]   r_pre;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_OCF_W-1:0]   r_oc_cnt;
    logic [c_FCNT_W-1:0]  r_fcnt;
    logic                 r_armed;
    logic [3:0]           w_dir;
    logic [11:0]          w_target;
    logic                 w_oc_any;
    logic                 w_oc_qual;

    always_comb begin
        w_dir = 4'b1001;
        if (sw[3:1] == 3'b001) begin
            w_dir = 4'b0110;
        end else if (sw[2] && !sw[3]) begin
            w_dir = 4'b0101;
        end else if (sw[3]) begin
            w_dir = 4'b1010;
        end
    end

    assign w_target  = {sw[7:4], 8'h00};
    assign w_oc_any  = |OC;
    assign w_oc_qual = w_oc_any && (r_oc_cnt >= c_OCF_ARM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            // r_armed holds off the first edge after reset release
            c_IDLE: if (sw[0] && r_armed) w_state_next = c_RAMP;
            c_RAMP, c_RUN: begin
                if (!sw[0]) begin
                    w_state_next = c_IDLE;
                end else if (w_dir != r_in) begin
                    w_state_next = c_DEAD;
                end else if (r_state == c_RAMP) begin
                    if (r_duty == w_target) w_state_next = c_RUN;
                end else if (w_target > r_duty) begin
                    w_state_next = c_RAMP;
                end
            end
            c_DEAD: begin
                if (!sw[0]) begin
                    w_state_next = c_IDLE;
                end else if (r_cnt == c_DEAD_LAST) begin
                    w_state_next = c_RAMP;
                end
            end
            c_FAULT: begin
                if (!w_oc_any) begin
`ifdef OC_AUTO_RETRY_EN
                    // r_fcnt already includes this fault, so MAX_RETRY faults still re-arm
                    w_state_next = (r_fcnt <= c_FCNT_W'(MAX_RETRY)) ? c_RETRY_WAIT : c_LOCKOUT;
`else
                    w_state_next = c_LOCKOUT;
`endif
                end
            end
            c_RETRY_WAIT: if (!w_oc_any && r_cnt == c_RETRY_LAST) w_state_next = c_IDLE;
            c_LOCKOUT: if (!sw[0]) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
        if (w_oc_qual && r_state != c_FAULT && r_state != c_LOCKOUT) begin
            w_state_next = c_FAULT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in     <= '0;
            r_duty   <= '0;
            r_pre    <= '0;
            r_cnt    <= '0;
            r_oc_cnt <= '0;
            r_fcnt   <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (!w_oc_any) begin
                r_oc_cnt <= '0;
            end else if (r_oc_cnt != c_OCF_MAX) begin
                r_oc_cnt <= r_oc_cnt + 1'b1;
            end

            if (w_state_next != r_state) begin
                r_cnt <= '0;
                r_pre <= '0;
                case (w_state_next)
                    c_RAMP: if (r_state != c_RUN) r_in <= w_dir;
                    c_DEAD: r_duty <= '0;
                    c_FAULT: begin
                        r_in   <= '0;
                        r_duty <= '0;
                        if (r_fcnt != c_FCNT_MAX) r_fcnt <= r_fcnt + 1'b1;
                    end
                    c_IDLE: begin
                        r_in   <= '0;
                        r_duty <= '0;
                        if (r_state == c_LOCKOUT) r_fcnt <= '0;
                    end
                    default: ;
                endcase
            end else begin
                case (r_state)
                    c_RAMP: begin
                        if (w_target < r_duty) begin
                            r_duty <= w_target;
                        end else if (r_pre == c_PRE_LAST) begin
                            r_pre <= '0;
                            if ({1'b0, r_duty} + c_STEP >= {1'b0, w_target}) begin
                                r_duty <= w_target;
                            end else begin
                                r_duty <= r_duty + c_STEP[11:0];
                            end
                        end else begin
                            r_pre <= r_pre + 1'b1;
                        end
                    end
                    c_RUN: begin
                        if (w_target < r_duty) r_duty <= w_target;
                        // sustained healthy running forgives earlier faults
                        if (r_cnt == c_RETRY_LAST) begin
                            r_fcnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    c_DEAD:       r_cnt <= r_cnt + 1'b1;
                    c_RETRY_WAIT: r_cnt <= w_oc_any ? '0 : r_cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign IN    = r_in;
    assign duty  = r_duty;
    assign EN    = (r_state == c_RAMP || r_state == c_RUN) ? {pulse, pulse} : 2'b00;
    assign fault = (r_state == c_FAULT) || (r_state == c_RETRY_WAIT) || (r_state == c_LOCKOUT);

endmodule
`default_nettype wire
